// File: rtl/controller_pkg.sv
// Shared ISA definitions for the RISC CPU: opcode and instruction-phase
// encodings, plus the ALU-class opcode membership helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    // Opcodes whose operand is read from memory and loaded into the accumulator
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/controller.sv
// 8-phase instruction sequencer with sticky HALTED state.
// Optional single-step gating at INST_ADDR when CTRL_STEP_EN is defined.
module controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef CTRL_STEP_EN
    input  logic       step,
`endif
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e
);

    phase_e r_phase;
    logic   r_halted;
    logic   w_aluop;
    logic   w_hold;

    assign w_aluop = is_aluop(opcode);

`ifdef CTRL_STEP_EN
    assign w_hold = (r_phase == INST_ADDR) && !step;
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (r_phase == OP_ADDR && opcode == HLT) begin
                r_halted <= 1'b1;
            end else if (!w_hold) begin
                r_phase <= phase_e'(r_phase + 3'd1);
            end
        end
    end

    // Strobes decode the live opcode/zero so SKZ sees zero within ALU_OP itself
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            case (r_phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: begin
                    rd = w_aluop;
                end
                ALU_OP: begin
                    rd     = w_aluop;
                    inc_pc = (opcode == SKZ) && zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    ld_pc  = (opcode == JMP);
                    wr     = (opcode == STO);
                    data_e = (opcode == STO);
                end
                default: ;
            endcase
        end
    end

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst) !(rd && wr));

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed vector table, HLT/reset
// sequences, and randomized cycles checked against a behavioural model.
module tb_controller;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
`ifdef CTRL_STEP_EN
    logic       step = 1'b1;
`endif

    controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
`ifdef CTRL_STEP_EN
        .step   (step),
`endif
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .halt   (halt),
        .inc_pc (inc_pc),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .wr     (wr),
        .data_e (data_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle order: sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e
    logic [8:0] w_out;
    assign w_out = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};

    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic       z;
        logic       chk;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(input logic r, input logic [2:0] op, input logic z,
                                input logic chk, input logic [8:0] exp);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endfunction

    // Fetch half of every instruction; opcode deliberately HLT to show it is ignored
    function automatic void add_fetch();
        add(0, 3'd0, 0, 1, 9'b100000000);
        add(0, 3'd0, 1, 1, 9'b110000000);
        add(0, 3'd0, 0, 1, 9'b111000000);
        add(0, 3'd0, 1, 1, 9'b111000000);
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e) at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Inputs held for one cycle; outputs sampled at the falling edge
    task automatic apply(input logic r, input logic [2:0] op, input logic z);
        rst = r; opcode = op; zero = z;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Reference: strobe set derived from phase number and opcode class
    function automatic logic [8:0] model_out(input int ph, input bit h,
                                             input logic [2:0] op, input logic z);
        bit alu;
        if (h) return 9'b000100000;
        alu = (op >= 3'd2) && (op <= 3'd5);
        return {ph <= 3,
                (ph >= 1 && ph <= 3) || (ph >= 5 && alu),
                ph == 2 || ph == 3,
                ph == 4 && op == 3'd0,
                ph == 4 || (ph == 6 && op == 3'd1 && z),
                ph == 7 && alu,
                (ph == 6 || ph == 7) && op == 3'd7,
                ph == 7 && op == 3'd6,
                (ph == 6 || ph == 7) && op == 3'd6};
    endfunction

    initial begin
        int  ph;
        bit  h;
        logic       r;
        logic [2:0] op;
        logic       z;

        // Reset: first cycle state unknown, second already in INST_ADDR
        add(1, 3'd0, 0, 0, 9'b000000000);
        add(1, 3'd5, 1, 1, 9'b100000000);
        // ADD
        add_fetch();
        add(0, 3'd2, 0, 1, 9'b000010000);
        add(0, 3'd2, 0, 1, 9'b010000000);
        add(0, 3'd2, 1, 1, 9'b010000000);
        add(0, 3'd2, 0, 1, 9'b010001000);
        // STO
        add_fetch();
        add(0, 3'd6, 0, 1, 9'b000010000);
        add(0, 3'd6, 0, 1, 9'b000000000);
        add(0, 3'd6, 1, 1, 9'b000000001);
        add(0, 3'd6, 0, 1, 9'b000000011);
        // SKZ zero=1: second PC increment in ALU_OP
        add_fetch();
        add(0, 3'd1, 1, 1, 9'b000010000);
        add(0, 3'd1, 1, 1, 9'b000000000);
        add(0, 3'd1, 1, 1, 9'b000010000);
        add(0, 3'd1, 1, 1, 9'b000000000);
        // SKZ zero=0, zero pulsed only in OP_FETCH
        add_fetch();
        add(0, 3'd1, 0, 1, 9'b000010000);
        add(0, 3'd1, 1, 1, 9'b000000000);
        add(0, 3'd1, 0, 1, 9'b000000000);
        add(0, 3'd1, 0, 1, 9'b000000000);
        // JMP
        add_fetch();
        add(0, 3'd7, 0, 1, 9'b000010000);
        add(0, 3'd7, 0, 1, 9'b000000000);
        add(0, 3'd7, 1, 1, 9'b000000100);
        add(0, 3'd7, 0, 1, 9'b000000100);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].op, vecs[i].z);
            if (vecs[i].chk) check($sformatf("vec%0d", i), w_out, vecs[i].exp);
            advance();
        end

        // HLT: halt asserted with the last inc_pc in OP_ADDR, then frozen
        add_fetch();
        for (int i = 0; i < 4; i++) begin
            apply(0, 3'd0, 0);
            check("hlt_fetch", w_out, vecs[vecs.size() - 4 + i].exp);
            advance();
        end
        apply(0, 3'd0, 0);
        check("hlt_op_addr", w_out, 9'b000110000);
        advance();
        for (int i = 0; i < 20; i++) begin
            apply(0, 3'($urandom_range(7)), 1'($urandom_range(1)));
            check("halted_hold", w_out, 9'b000100000);
            advance();
        end
        apply(1, 3'd2, 1);
        check("halted_in_rst", w_out, 9'b000100000);
        advance();
        apply(0, 3'd2, 1);
        check("after_rst", w_out, 9'b100000000);
        advance();
        apply(0, 3'd2, 1);
        check("after_rst_next", w_out, 9'b110000000);
        advance();

        // Mid-cycle reset from STORE
        for (int i = 0; i < 5; i++) begin
            apply(0, 3'd6, 0);
            advance();
        end
        apply(1, 3'd6, 0);
        check("rst_in_store", w_out, 9'b000000011);
        advance();
        apply(0, 3'd6, 0);
        check("after_mid_rst", w_out, 9'b100000000);
        advance();

        // Randomized run against the model, occasional resets
        apply(1, 3'd0, 0);
        advance();
        ph = 0;
        h  = 0;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(15) == 0);
            op = 3'($urandom_range(7));
            z  = 1'($urandom_range(1));
            apply(r, op, z);
            check("random", w_out, model_out(ph, h, op, z));
            if (r) begin
                ph = 0;
                h  = 0;
            end else if (!h) begin
                if (ph == 4 && op == 3'd0) h = 1;
                else ph = (ph + 1) % 8;
            end
            advance();
        end

`ifdef CTRL_STEP_EN
        apply(1, 3'd2, 0);
        advance();
        step = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply(0, 3'd2, 0);
            check("step_wait", w_out, 9'b100000000);
            advance();
        end
        step = 1'b1;
        apply(0, 3'd2, 0);
        check("step_go", w_out, 9'b100000000);
        advance();
        step = 1'b0;
        for (int p = 1; p < 8; p++) begin
            apply(0, 3'd2, 0);
            check("step_cycle", w_out, model_out(p, 0, 3'd2, 0));
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 3'd2, 0);
            check("step_rewait", w_out, 9'b100000000);
            advance();
        end
        step = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
